// File: rtl/char_bitmap_fetch_if.sv
// Glyph fetch bus: charHandler request/column select, font ROM handshake, pixel/status outputs.
interface char_bitmap_fetch_if #(
    parameter int ROW_BITS  = 4,
    parameter int COL_BITS  = 3,
    parameter int CODE_BITS = 7
);
    logic                          readEn;
    logic [ROW_BITS-1:0]           rowCnt;
    logic [COL_BITS-1:0]           colCnt;
    logic [CODE_BITS-1:0]          charCode;
    logic                          romReq;
    logic [CODE_BITS+ROW_BITS-1:0] romAddr;
    logic [7:0]                    romData;
    logic                          romValid;
    logic                          bitDisp;
    logic                          rowReady;
    logic                          fetchErr;

    modport slave (
        input  readEn, rowCnt, colCnt, charCode, romData, romValid,
        output romReq, romAddr, bitDisp, rowReady, fetchErr
    );

    modport master (
        output readEn, rowCnt, colCnt, charCode, romData, romValid,
        input  romReq, romAddr, bitDisp, rowReady, fetchErr
    );
endinterface

// File: rtl/char_bitmap_fetch.sv
// Glyph row fetcher: latches {charCode,rowCnt}, reads one row byte from the font ROM, serves pixels.
// Optional CHAR_UNDERLINE_EN: the all-ones glyph row displays as solid 8'hFF.
module char_bitmap_fetch #(
    parameter int ROW_BITS  = 4,
    parameter int COL_BITS  = 3,
    parameter int CODE_BITS = 7,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    char_bitmap_fetch_if.slave   bus
);
    localparam int ADDR_BITS = CODE_BITS + ROW_BITS;
    localparam int TMR_BITS  = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state, state_nxt;
    logic [ADDR_BITS-1:0]  rom_addr, pend_addr, req_addr, issue_addr;
    logic                  pend_vld, rom_req, row_ready, fetch_err;
    logic [TMR_BITS-1:0]   timer;
    logic [7:0]            display_row, load_val;
    logic [COL_BITS-1:0]   col_sel;
    logic                  issue, done_ok, done_to, to_pending, overrun;

    assign req_addr = {bus.charCode, bus.rowCnt};
    assign col_sel  = bus.colCnt;

`ifdef CHAR_UNDERLINE_EN
    assign load_val = (&rom_addr[ROW_BITS-1:0]) ? 8'hFF : bus.romData;
`else
    assign load_val = bus.romData;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_addr = req_addr;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        to_pending = 1'b0;
        overrun    = 1'b0;
        case (state)
            IDLE: begin
                // A buffered request goes first; a fresh readEn refills the buffer.
                if (pend_vld) begin
                    issue      = 1'b1;
                    issue_addr = pend_addr;
                    to_pending = bus.readEn;
                end else if (bus.readEn) begin
                    issue = 1'b1;
                end
                if (issue) state_nxt = REQ;
            end
            REQ: begin
                if (bus.romValid)                            done_ok = 1'b1;
                else if (timer == TMR_BITS'(TIMEOUT - 1))    done_to = 1'b1;
                if (done_ok || done_to) state_nxt = IDLE;
                if (bus.readEn) begin
                    if (pend_vld) overrun    = 1'b1;
                    else          to_pending = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_addr    <= '0;
            rom_req     <= 1'b0;
            timer       <= '0;
            display_row <= '0;
            row_ready   <= 1'b0;
            fetch_err   <= 1'b0;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
        end else begin
            row_ready <= done_ok;
            if (issue) begin
                rom_addr <= issue_addr;
                rom_req  <= 1'b1;
                timer    <= '0;
            end else if (done_ok || done_to) begin
                rom_req <= 1'b0;
            end else if (state == REQ) begin
                timer <= timer + 1'b1;
            end
            if (done_ok) display_row <= load_val;
            if (done_to) display_row <= '0;
            if (done_to || overrun) fetch_err <= 1'b1;
            if (to_pending) begin
                pend_vld  <= 1'b1;
                pend_addr <= req_addr;
            end else if (issue && pend_vld) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign bus.romReq   = rom_req;
    assign bus.romAddr  = rom_addr;
    assign bus.rowReady = row_ready;
    assign bus.fetchErr = fetch_err;
    assign bus.bitDisp  = display_row[3'd7 - col_sel[2:0]];
endmodule

// File: tb/tb_char_bitmap_fetch.sv
// Bench for char_bitmap_fetch: vector table plus hand-built corner sequences, row scoreboard.
module tb_char_bitmap_fetch;
    localparam int ROW_BITS  = 4;
    localparam int COL_BITS  = 3;
    localparam int CODE_BITS = 7;
    localparam int TIMEOUT   = 15;

    logic clock = 1'b0;
    logic reset;
    always #10 clock = ~clock;

    char_bitmap_fetch_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .CODE_BITS(CODE_BITS)) bus();

    char_bitmap_fetch #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .CODE_BITS(CODE_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [6:0]  code;
        logic [3:0]  row;
        logic [7:0]  data;
        int          delay;
        logic [10:0] exp_addr;
        logic [7:0]  exp_row;
    } vec_t;

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_row;
    vec_t       vecs[7];

    function automatic logic [7:0] model_row(input logic [3:0] row, input logic [7:0] data);
`ifdef CHAR_UNDERLINE_EN
        if (row == 4'hF) return 8'hFF;
`endif
        return data;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic sweep(output logic [7:0] got);
        for (int c = 0; c < 8; c++) begin
            bus.colCnt = 3'(c);
            #1;
            got[7-c] = bus.bitDisp;
        end
    endtask

    task automatic check_row(input string name);
        logic [7:0] got, exp;
        check({name, "_ready"}, bus.rowReady, 1);
        sweep(got);
        if (sb_q.size() == 0) check({name, "_sb_empty"}, 0, 1);
        else begin
            exp = sb_q.pop_front();
            check(name, got, exp);
            last_row = exp;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.readEn = 1'b0;
        bus.romValid = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
    endtask

    task automatic fetch(input vec_t v);
        bus.charCode = v.code;
        bus.rowCnt   = v.row;
        bus.readEn   = 1'b1;
        tick;
        bus.readEn = 1'b0;
        check("romReq_rise", bus.romReq, 1);
        check("romAddr", bus.romAddr, v.exp_addr);
        for (int d = 0; d < v.delay; d++) begin
            tick;
            check("romReq_hold", bus.romReq, 1);
        end
        bus.romData  = v.data;
        bus.romValid = 1'b1;
        sb_q.push_back(v.exp_row);
        tick;
        bus.romValid = 1'b0;
        check_row("row");
        tick;
        check("rowReady_pulse", bus.rowReady, 0);
        check("romReq_fall", bus.romReq, 0);
    endtask

    initial begin
        logic [7:0] got;
        int n;
        bus.readEn = 0; bus.rowCnt = 0; bus.colCnt = 0; bus.charCode = 0;
        bus.romData = 0; bus.romValid = 0;
        last_row = 8'h00;

        vecs[0] = '{7'h41, 4'd3, 8'h81, 1, 11'h413, 8'h00};
        vecs[1] = '{7'h00, 4'd0, 8'h7E, 0, 11'h000, 8'h00};
        vecs[2] = '{7'h7F, 4'hE, 8'hFF, 0, 11'h7FE, 8'h00};
        vecs[3] = '{7'h2A, 4'd5, 8'hA5, 3, 11'h2A5, 8'h00};
        vecs[4] = '{7'h15, 4'd9, 8'h3C, 7, 11'h159, 8'h00};
        vecs[5] = '{7'h7F, 4'hF, 8'h00, 2, 11'h7FF, 8'h00};
        vecs[6] = '{7'h01, 4'hF, 8'h5A, 0, 11'h01F, 8'h00};
        foreach (vecs[i]) vecs[i].exp_row = model_row(vecs[i].row, vecs[i].data);

        // reset state
        do_reset;
        tick;
        check("rst_romReq", bus.romReq, 0);
        check("rst_romAddr", bus.romAddr, 0);
        check("rst_rowReady", bus.rowReady, 0);
        check("rst_fetchErr", bus.fetchErr, 0);
        sweep(got);
        check("rst_bitDisp", got, 8'h00);

        foreach (vecs[i]) fetch(vecs[i]);
        check("no_err_after_table", bus.fetchErr, 0);

        // romValid while idle is ignored
        bus.romData = 8'hC3; bus.romValid = 1'b1;
        tick;
        bus.romValid = 1'b0;
        check("idle_valid_rowReady", bus.rowReady, 0);
        check("idle_valid_romReq", bus.romReq, 0);
        sweep(got);
        check("idle_valid_row", got, last_row);

        // pending buffer: 2nd request queued, 3rd dropped with error
        tick;
        bus.charCode = 7'h41; bus.rowCnt = 4'd1; bus.readEn = 1'b1;
        tick;
        check("pend_a_addr", bus.romAddr, 11'h411);
        bus.charCode = 7'h42; bus.rowCnt = 4'd2;
        tick;
        check("pend_err_before", bus.fetchErr, 0);
        bus.charCode = 7'h43; bus.rowCnt = 4'd3;
        tick;
        bus.readEn = 1'b0;
        check("overrun_err", bus.fetchErr, 1);
        bus.romData = 8'h18; bus.romValid = 1'b1; sb_q.push_back(8'h18);
        tick;
        bus.romValid = 1'b0;
        check_row("pend_a_row");
        check("pend_gap_low", bus.romReq, 0);
        tick;
        check("pend_b_req", bus.romReq, 1);
        check("pend_b_addr", bus.romAddr, 11'h422);
        bus.romData = 8'hE7; bus.romValid = 1'b1; sb_q.push_back(8'hE7);
        tick;
        bus.romValid = 1'b0;
        check_row("pend_b_row");
        n = 0;
        repeat (3) begin tick; if (bus.romReq) n++; end
        check("dropped_not_issued", n, 0);

        // readEn coincident with romValid: load completes, new request follows
        bus.charCode = 7'h50; bus.rowCnt = 4'd4; bus.readEn = 1'b1;
        tick;
        bus.charCode = 7'h55; bus.rowCnt = 4'd6;
        bus.romData = 8'h42; bus.romValid = 1'b1; sb_q.push_back(8'h42);
        tick;
        bus.readEn = 1'b0; bus.romValid = 1'b0;
        check_row("coinc_row");
        check("coinc_gap_low", bus.romReq, 0);
        tick;
        check("coinc_next_addr", bus.romAddr, 11'h556);
        check("coinc_next_req", bus.romReq, 1);
        bus.romData = 8'h99; bus.romValid = 1'b1; sb_q.push_back(8'h99);
        tick;
        bus.romValid = 1'b0;
        check_row("coinc_next_row");

        // timeout: romReq held exactly TIMEOUT cycles, row cleared, sticky error
        do_reset;
        bus.charCode = 7'h10; bus.rowCnt = 4'd2; bus.readEn = 1'b1;
        tick;
        bus.readEn = 1'b0;
        n = 0;
        while (bus.romReq && n < 40) begin
            n++;
            if (bus.rowReady) check("to_spurious_ready", bus.rowReady, 0);
            tick;
        end
        check("to_req_cycles", n, TIMEOUT);
        check("to_err", bus.fetchErr, 1);
        sweep(got);
        check("to_bitDisp", got, 8'h00);
        fetch(vecs[0]);
        check("to_err_sticky", bus.fetchErr, 1);

        // reset mid-fetch, then a late romValid
        bus.charCode = 7'h33; bus.rowCnt = 4'd7; bus.readEn = 1'b1;
        tick;
        bus.readEn = 1'b0;
        check("rstreq_req", bus.romReq, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.romData = 8'hFF; bus.romValid = 1'b1;
        tick;
        bus.romValid = 1'b0;
        check("rstreq_romReq", bus.romReq, 0);
        check("rstreq_romAddr", bus.romAddr, 0);
        check("rstreq_rowReady", bus.rowReady, 0);
        check("rstreq_fetchErr", bus.fetchErr, 0);
        sweep(got);
        check("rstreq_bitDisp", got, 8'h00);
        tick;
        check("rstreq_idle", bus.romReq, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
